// File: rtl/gumnut_pkg.sv
// rtl/gumnut_pkg.sv - shared widths, fetch FSM state type and timeout default
package gumnut_pkg;

  localparam int INST_W          = 18;
  localparam int ADDR_W          = 12;
  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: PC, bus fetch with timeout, instruction latch
module inst_fetch
  import gumnut_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_req_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] pc_load_val_i,
  output logic              inst_cyc_o,
  output logic              inst_stb_o,
  output logic [ADDR_W-1:0] inst_adr_o,
  input  logic              inst_ack_i,
  input  logic [INST_W-1:0] inst_dat_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              fetch_err_o
);

  // Counter value seen during the last permitted WAIT_ACK cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [ADDR_W-1:0] pend_val_q, pend_val_d;
  logic              pend_q, pend_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              timeout_hit;
  logic              take_load;
  logic [ADDR_W-1:0] load_val;

  assign timeout_hit = (cnt_q == CNT_LAST);
  // A load arriving in the completing cycle is newer than any pending one.
  assign take_load   = pc_load_i | pend_q;
  assign load_val    = pc_load_i ? pc_load_val_i : pend_val_q;

  // State register; reset abandons any outstanding fetch immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: start on request, finish on ack or timeout (ack has priority via datapath).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fetch_req_i) state_d = WAIT_ACK;
      WAIT_ACK: if (inst_ack_i || timeout_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath next-state: PC, fetch address, pending load, capture and pulses.
  always_comb begin
    pc_d       = pc_q;
    adr_d      = adr_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    inst_d     = inst_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_load_i) pc_d = pc_load_val_i;
        if (fetch_req_i) begin
          adr_d = pc_load_i ? pc_load_val_i : pc_q;
          cnt_d = '0;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (pc_load_i) begin
          pend_d     = 1'b1;
          pend_val_d = pc_load_val_i;
        end
        if (inst_ack_i) begin
          inst_d  = inst_dat_i;
          valid_d = 1'b1;
          pc_d    = take_load ? load_val : adr_q + 1'b1;
          pend_d  = 1'b0;
        end else if (timeout_hit) begin
          err_d  = 1'b1;
          pend_d = 1'b0;
          if (take_load) pc_d = load_val;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= '0;
      adr_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      inst_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      adr_q      <= adr_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      inst_q     <= inst_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Outputs: bus cycle follows the state directly so reset drops it asynchronously.
  always_comb begin
    inst_cyc_o   = (state_q == WAIT_ACK);
    inst_stb_o   = (state_q == WAIT_ACK);
    busy_o       = (state_q == WAIT_ACK);
    inst_adr_o   = adr_q;
    inst_o       = inst_q;
    inst_valid_o = valid_q;
    pc_o         = pc_q;
    fetch_err_o  = err_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch with instruction scoreboard
module tb_inst_fetch;
  import gumnut_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_req;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              cyc, stb;
  logic [ADDR_W-1:0] adr;
  logic              ack;
  logic [INST_W-1:0] dat;
  logic [INST_W-1:0] inst;
  logic              valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [INST_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fetch_req_i  (fetch_req),
    .pc_load_i    (pc_load),
    .pc_load_val_i(pc_load_val),
    .inst_cyc_o   (cyc),
    .inst_stb_o   (stb),
    .inst_adr_o   (adr),
    .inst_ack_i   (ack),
    .inst_dat_i   (dat),
    .inst_o       (inst),
    .inst_valid_o (valid),
    .pc_o         (pc),
    .busy_o       (busy),
    .fetch_err_o  (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_inst(input string tag);
    logic [INST_W-1:0] e;
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    if (exp_q.size() == 0) begin
      total++;
      fails++;
      $error("FAIL %s_sb: observed inst %0h expected none queued", tag, inst);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_inst"}, 32'(inst), 32'(e));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cyc"},   32'(cyc),   32'd0);
    chk({tag, "_stb"},   32'(stb),   32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_err"},   32'(err),   32'd0);
    chk({tag, "_pc"},    32'(pc),    32'h000);
    chk({tag, "_adr"},   32'(adr),   32'h000);
    chk({tag, "_inst"},  32'(inst),  32'h00000);
  endtask

  initial begin
    int cyc_cnt;
    int err_cnt;
    int val_cnt;

    rst_n       = 1'b0;
    fetch_req   = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    ack         = 1'b0;
    dat         = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Zero-wait fetch from 0x000
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t1_cyc",  32'(cyc),  32'd1);
    chk("t1_stb",  32'(stb),  32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_adr",  32'(adr),  32'h000);
    ack = 1'b1;
    dat = 18'h2A5C3;
    exp_q.push_back(18'h2A5C3);
    step();
    ack = 1'b0;
    expect_inst("t1");
    chk("t1_pc",   32'(pc),  32'h001);
    chk("t1_cyc2", 32'(cyc), 32'd0);
    step();
    chk("t1_pulse", 32'(valid), 32'd0);
    chk("t1_hold",  32'(inst),  32'h2A5C3);

    // Ack while idle is ignored
    ack = 1'b1;
    dat = 18'h11111;
    step();
    ack = 1'b0;
    chk("idle_ack_valid", 32'(valid), 32'd0);
    chk("idle_ack_cyc",   32'(cyc),   32'd0);
    chk("idle_ack_inst",  32'(inst),  32'h2A5C3);
    chk("idle_ack_pc",    32'(pc),    32'h001);

    // Load 0xFFF with fetch, ack on 4th wait cycle (also the timeout-race cycle)
    pc_load     = 1'b1;
    pc_load_val = 12'hFFF;
    fetch_req   = 1'b1;
    step();
    pc_load   = 1'b0;
    fetch_req = 1'b0;
    chk("t2_adr0", 32'(adr), 32'hFFF);
    chk("t2_pc0",  32'(pc),  32'hFFF);
    chk("t2_cyc0", 32'(cyc), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      fetch_req = 1'b1;
      step();
      chk($sformatf("t2_adr%0d", i), 32'(adr), 32'hFFF);
      chk($sformatf("t2_cyc%0d", i), 32'(cyc), 32'd1);
      chk($sformatf("t2_err%0d", i), 32'(err), 32'd0);
    end
    fetch_req = 1'b0;
    ack = 1'b1;
    dat = 18'h3FFFF;
    exp_q.push_back(18'h3FFFF);
    step();
    ack = 1'b0;
    expect_inst("t2");
    chk("t2_pc_wrap", 32'(pc),  32'h000);
    chk("t2_err",     32'(err), 32'd0);
    chk("t2_cyc",     32'(cyc), 32'd0);
    step();
    chk("t2_err_late", 32'(err), 32'd0);
    chk("t2_idle",     32'(cyc), 32'd0);

    // Timeout with no ack
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    cyc_cnt = 0;
    err_cnt = 0;
    val_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (cyc) cyc_cnt++;
      if (err) err_cnt++;
      if (valid) val_cnt++;
      step();
    end
    chk("t3_cyc_cycles", 32'(cyc_cnt), 32'd4);
    chk("t3_err_pulses", 32'(err_cnt), 32'd1);
    chk("t3_valid_seen", 32'(val_cnt), 32'd0);
    chk("t3_pc",         32'(pc),      32'h000);
    chk("t3_inst",       32'(inst),    32'h3FFFF);

    // Load during WAIT_ACK replaces the increment
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t4_adr", 32'(adr), 32'h000);
    pc_load     = 1'b1;
    pc_load_val = 12'h123;
    step();
    pc_load = 1'b0;
    chk("t4_pc_pending", 32'(pc),  32'h000);
    chk("t4_cyc",        32'(cyc), 32'd1);
    ack = 1'b1;
    dat = 18'h0ABCD;
    exp_q.push_back(18'h0ABCD);
    step();
    ack = 1'b0;
    expect_inst("t4a");
    chk("t4_pc_load", 32'(pc), 32'h123);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t4_adr_next", 32'(adr), 32'h123);
    ack = 1'b1;
    dat = 18'h15555;
    exp_q.push_back(18'h15555);
    step();
    ack = 1'b0;
    expect_inst("t4b");
    chk("t4_pc_inc", 32'(pc), 32'h124);

    // Reset two cycles into WAIT_ACK
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    chk("t5_pre_cyc", 32'(cyc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    step();
    rst_n = 1'b1;
    step();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t5_adr", 32'(adr), 32'h000);
    ack = 1'b1;
    dat = 18'h00042;
    exp_q.push_back(18'h00042);
    step();
    ack = 1'b0;
    expect_inst("t5");
    chk("t5_pc", 32'(pc), 32'h001);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
